// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-wire slave: state encoding, default bus timing, read command.
// Timing defaults match the team's 1-wire master so both sides agree on slot lengths.
package onewire_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRES_WAIT = 3'd1,
    ST_PRES_DRV  = 3'd2,
    ST_CMD_RX    = 3'd3,
    ST_TX_SLOT   = 3'd4,
    ST_DONE      = 3'd5
  } ow_state_t;

  localparam int unsigned OW_CNT_W    = 16;
  localparam int unsigned OW_RST_MIN  = 24000;
  localparam int unsigned OW_PRES_DLY = 500;
  localparam int unsigned OW_PRES_LEN = 4000;
  localparam int unsigned OW_TX_HOLD  = 3500;
  localparam int unsigned OW_WR_SMP   = 3000;
  localparam logic [7:0]  OW_READ_CMD = 8'hBE;

endpackage

// File: rtl/onewire_sync.sv
// Bus input conditioning: 2-flop synchroniser, fall/rise pulses and a low-time counter
// that flags a bus reset when the line is released after a long enough external low.
module onewire_sync
  import onewire_pkg::*;
#(
  parameter int unsigned CNT_W   = OW_CNT_W,
  parameter int unsigned RST_MIN = OW_RST_MIN
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_dq,
  input  logic i_own,
  output logic o_line,
  output logic o_fall,
  output logic o_rise,
  output logic o_rst_det
);

  logic             r_meta;
  logic             r_line;
  logic             r_line_d;
  logic [CNT_W-1:0] r_low_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Flops idle high so leaving reset never produces a spurious fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta    <= 1'b1;
      r_line    <= 1'b1;
      r_line_d  <= 1'b1;
      r_low_cnt <= '0;
    end else begin
      r_meta   <= i_dq;
      r_line   <= r_meta;
      r_line_d <= r_line;
      // Low time only accumulates while we are not pulling the bus ourselves.
      if (r_line)
        r_low_cnt <= '0;
      else if (!i_own)
        r_low_cnt <= sat_inc(r_low_cnt);
    end
  end

  assign o_line    = r_line;
  assign o_fall    = r_line_d & ~r_line;
  assign o_rise    = ~r_line_d & r_line;
  assign o_rst_det = o_rise && (r_low_cnt >= CNT_W'(RST_MIN));

endmodule

// File: rtl/onewire_slave.sv
// Single-device 1-wire responder: presence pulse after bus reset, then serves 8 read slots
// LSB first from a latched byte. Define ONEWIRE_CMD_EN to require a READ_CMD write first.
module onewire_slave
  import onewire_pkg::*;
#(
  parameter int unsigned CNT_W    = OW_CNT_W,
  parameter int unsigned RST_MIN  = OW_RST_MIN,
  parameter int unsigned PRES_DLY = OW_PRES_DLY,
  parameter int unsigned PRES_LEN = OW_PRES_LEN,
  parameter int unsigned TX_HOLD  = OW_TX_HOLD,
  parameter int unsigned WR_SMP   = OW_WR_SMP,
  parameter logic [7:0]  READ_CMD = OW_READ_CMD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dq_in,
  output logic       dq_oe,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       tx_done,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       rst_seen
);

  localparam logic [CNT_W-1:0] C_PRES_DLY = CNT_W'(PRES_DLY);
  localparam logic [CNT_W-1:0] C_PRES_LEN = CNT_W'(PRES_LEN);
  localparam logic [CNT_W-1:0] C_TX_HOLD  = CNT_W'(TX_HOLD);

  ow_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic             r_slot;
  logic [7:0]       r_shift;
  logic             r_oe;
  logic             r_busy;
  logic             r_tx_done;
  logic [7:0]       r_cmd;
  logic             r_cmd_valid;
  logic             r_rst_seen;

  logic w_line;
  logic w_fall;
  logic w_rise;
  logic w_rst_det;
  logic w_fall_ext;
  logic w_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  onewire_sync #(
    .CNT_W  (CNT_W),
    .RST_MIN(RST_MIN)
  ) u_sync (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_dq     (dq_in),
    .i_own    (r_oe),
    .o_line   (w_line),
    .o_fall   (w_fall),
    .o_rise   (w_rise),
    .o_rst_det(w_rst_det)
  );

  // Falls caused by our own pull are not slot starts.
  assign w_fall_ext = w_fall & ~r_oe;

`ifdef ONEWIRE_CMD_EN
  localparam logic [CNT_W-1:0] C_WR_SMP = CNT_W'(WR_SMP);
  logic [7:0] r_cmd_sh;
  logic [7:0] w_cmd_next;
  assign w_cmd_next = {w_line, r_cmd_sh[6:0]};
  assign w_unused   = w_rise;
`else
  assign w_unused   = w_rise ^ w_line ^ (^READ_CMD) ^ (^WR_SMP);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_slot      <= 1'b0;
      r_shift     <= '0;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_done   <= 1'b0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_rst_seen  <= 1'b0;
`ifdef ONEWIRE_CMD_EN
      r_cmd_sh    <= '0;
`endif
    end else begin
      r_tx_done   <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_rst_seen  <= 1'b0;
      r_cnt       <= w_fall_ext ? '0 : sat_inc(r_cnt);
      // A bus reset overrides whatever the FSM would do this cycle.
      if (w_rst_det) begin
        r_rst_seen <= 1'b1;
        r_cnt      <= '0;
        r_bit      <= '0;
        r_slot     <= 1'b0;
        r_oe       <= 1'b0;
        r_busy     <= 1'b1;
        r_state    <= ST_PRES_WAIT;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_oe   <= 1'b0;
            r_busy <= 1'b0;
          end
          ST_PRES_WAIT: begin
            if (r_cnt == C_PRES_DLY) begin
              r_oe    <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_PRES_DRV;
            end
          end
          ST_PRES_DRV: begin
            if (r_cnt == C_PRES_LEN) begin
              r_oe    <= 1'b0;
              r_shift <= tx_data;
              r_bit   <= '0;
              r_slot  <= 1'b0;
`ifdef ONEWIRE_CMD_EN
              r_state <= ST_CMD_RX;
`else
              r_state <= ST_TX_SLOT;
`endif
            end
          end
`ifdef ONEWIRE_CMD_EN
          ST_CMD_RX: begin
            if (w_fall_ext) begin
              r_slot <= 1'b1;
            end else if (r_slot && r_cnt == C_WR_SMP) begin
              r_slot          <= 1'b0;
              r_cmd_sh[r_bit] <= w_line;
              r_bit           <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_cmd       <= w_cmd_next;
                r_cmd_valid <= 1'b1;
                r_bit       <= '0;
                if (w_cmd_next == READ_CMD) begin
                  r_state <= ST_TX_SLOT;
                end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_DONE;
                end
              end
            end
          end
`endif
          ST_TX_SLOT: begin
            if (w_fall_ext) begin
              r_slot <= 1'b1;
              if (!r_shift[r_bit])
                r_oe <= 1'b1;
            end else if (r_slot && r_cnt == C_TX_HOLD) begin
              r_oe   <= 1'b0;
              r_slot <= 1'b0;
              r_bit  <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_tx_done <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= ST_DONE;
              end
            end
          end
          default: begin
            r_oe   <= 1'b0;
            r_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dq_oe     = r_oe;
  assign busy      = r_busy;
  assign tx_done   = r_tx_done;
  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign rst_seen  = r_rst_seen;

endmodule
